// File: rtl/dma_engine_if.sv
// Bus-side signal bundle between the DMA engine (master) and a memory/peripheral
// responder (slave). Read_data is returned combinationally from Address.
interface dma_engine_if;
  logic        bus_grant;
  logic [31:0] Read_data;
  logic [31:0] Address;
  logic [31:0] Write_data;
  logic        MemRead;
  logic        MemWrite;

  modport master (
    input  bus_grant,
    input  Read_data,
    output Address,
    output Write_data,
    output MemRead,
    output MemWrite
  );

  modport slave (
    output bus_grant,
    output Read_data,
    input  Address,
    input  Write_data,
    input  MemRead,
    input  MemWrite
  );
endinterface

// File: rtl/dma_engine.sv
// Word-copy DMA engine: READ/WRITE ping-pong over a granted bus, sticky irq on completion.
// Define DMA_FILL_EN to add pattern-fill mode (src_addr used as the pattern, WRITE-only loop).
module dma_engine #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [31:0]        src_addr,
  input  logic [31:0]        dst_addr,
  input  logic [COUNT_W-1:0] word_count,
  input  logic               fill_mode,
  dma_engine_if.master       bus,
  output logic               busy,
  output logic               done,
  output logic               irq,
  input  logic               irq_clr
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

  state_e             state_q;
  logic [31:0]        src_q;
  logic [31:0]        dst_q;
  logic [31:0]        data_q;
  logic [COUNT_W-1:0] remaining_q;
  logic               irq_q;
  logic               bus_go;

`ifdef DMA_FILL_EN
  logic               fill_q;
`else
  logic               unused_fill;
  assign unused_fill = fill_mode;
`endif

  // An abort cycle never issues a strobe, even with the bus granted.
  assign bus_go = bus.bus_grant && !abort;

  assign busy = (state_q == READ) || (state_q == WRITE);
  assign done = (state_q == DONE);
  assign irq  = irq_q;

  always_comb begin
    bus.Address    = '0;
    bus.Write_data = '0;
    bus.MemRead    = 1'b0;
    bus.MemWrite   = 1'b0;
    if (state_q == READ && bus_go) begin
      bus.Address = src_q;
      bus.MemRead = 1'b1;
    end else if (state_q == WRITE && bus_go) begin
      bus.Address    = dst_q;
      bus.Write_data = data_q;
      bus.MemWrite   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      src_q       <= '0;
      dst_q       <= '0;
      data_q      <= '0;
      remaining_q <= '0;
      irq_q       <= 1'b0;
`ifdef DMA_FILL_EN
      fill_q      <= 1'b0;
`endif
    end else begin
      // Completion set wins over a coincident clear.
      if (state_q == DONE) begin
        irq_q <= 1'b1;
      end else if (irq_clr) begin
        irq_q <= 1'b0;
      end

      unique case (state_q)
        IDLE: begin
          if (start && !abort) begin
            src_q       <= src_addr & 32'hFFFF_FFFC;
            dst_q       <= dst_addr & 32'hFFFF_FFFC;
            remaining_q <= word_count;
`ifdef DMA_FILL_EN
            fill_q <= fill_mode;
            if (fill_mode) begin
              data_q <= src_addr;
            end
            if (word_count == '0) begin
              state_q <= DONE;
            end else begin
              state_q <= fill_mode ? WRITE : READ;
            end
`else
            state_q <= (word_count == '0) ? DONE : READ;
`endif
          end
        end
        READ: begin
          if (abort) begin
            state_q <= IDLE;
          end else if (bus.bus_grant) begin
            data_q  <= bus.Read_data;
            src_q   <= src_q + 32'd4;
            state_q <= WRITE;
          end
        end
        WRITE: begin
          if (abort) begin
            state_q <= IDLE;
          end else if (bus.bus_grant) begin
            dst_q       <= dst_q + 32'd4;
            remaining_q <= remaining_q - COUNT_W'(1);
            if (remaining_q == COUNT_W'(1)) begin
              state_q <= DONE;
`ifdef DMA_FILL_EN
            end else if (fill_q) begin
              state_q <= WRITE;
`endif
            end else begin
              state_q <= READ;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/dma_engine.md
DMA_ENGINE -- requirements
Module: dma_engine

Interface
REQ-001 SHALL have parameter COUNT_W, default 16, width of the word-count field.
REQ-002 SHALL have port clk, input, 1, the single system clock; every state change occurs on its rising edge.
REQ-003 SHALL have port reset, input, 1; reset is synchronous and active-low.
REQ-004 SHALL have port start, input, 1, a request to begin a transfer; it is sampled only in IDLE.
REQ-005 SHALL have port abort, input, 1, which terminates an active transfer.
REQ-006 SHALL have port src_addr, input, 32, the source byte address.
REQ-007 SHALL have port dst_addr, input, 32, the destination byte address.
REQ-008 SHALL have port word_count, input, COUNT_W, the number of 32-bit words to transfer.
REQ-009 SHALL have port fill_mode, input, 1, which selects pattern fill; it is used only under DMA_FILL_EN.
REQ-010 SHALL have port bus_grant, input, 1; while it is high the CPU has released the data bus to the engine.
REQ-011 SHALL have port Read_data, input, 32, the combinational read data returned by the memory/peripheral responder.
REQ-012 SHALL have port Address, output, 32, the bus byte address.
REQ-013 SHALL have port Write_data, output, 32, the bus write data.
REQ-014 SHALL have port MemRead, output, 1, the bus read strobe.
REQ-015 SHALL have port MemWrite, output, 1, the bus write strobe; the responder commits the write on the next clk edge.
REQ-016 SHALL have port busy, output, 1, which is high in the READ and WRITE states.
REQ-017 SHALL have port done, output, 1, a one-cycle pulse in the DONE state.
REQ-018 SHALL have ports irq (output, 1) and irq_clr (input, 1); irq is a sticky completion flag and irq_clr clears it.

Function
REQ-019 SHALL implement the FSM states IDLE, READ, WRITE and DONE.
REQ-020 SHALL, in IDLE with start=1 and abort=0, latch src_addr and dst_addr (each with bits[1:0] forced to 0) and word_count, then go to READ, or go to DONE if word_count=0.
REQ-021 SHALL, in READ with bus_grant=1, drive Address=src, MemRead=1, capture Read_data into a 32-bit holding register at the edge, add 4 to src, and go to WRITE.
REQ-022 SHALL, in WRITE with bus_grant=1, drive Address=dst, MemWrite=1 and Write_data=holding register, add 4 to dst, and decrement remaining; it SHALL go to DONE when remaining reaches 0 and to READ otherwise.
REQ-023 SHALL, with bus_grant=0 in READ or WRITE, hold the state and all counters, and drive MemRead=0, MemWrite=0, Address=0 and Write_data=0.
REQ-024 SHALL drive Address, Write_data, MemRead and MemWrite all to 0 in IDLE and DONE.
REQ-025 SHALL, in DONE, assert done=1 and set irq for one cycle, then return to IDLE.
REQ-026 SHALL, with abort=1 in READ or WRITE, return to IDLE at the next edge with no bus strobe that cycle, no done pulse and no irq change.
REQ-027 SHALL let abort take priority when start=1 and abort=1 occur together in IDLE; the start is ignored.
REQ-028 SHALL let the set take priority when irq_clr=1 coincides with an irq set in DONE; irq stays 1.
REQ-029 SHALL wrap address increments modulo 2^32, so 32'hFFFFFFFC+4 gives 0.
REQ-030 SHALL ignore start while not in IDLE, including start asserted in DONE.
REQ-031 SHALL take exactly 2*N+1 cycles from the start edge through the DONE cycle with bus_grant held high (N = word_count).

Reset
REQ-032 SHALL, when reset=0 at a clk edge, enter IDLE and clear src, dst, remaining and the holding register, and set busy=0, done=0, irq=0, Address=0, Write_data=0, MemRead=0 and MemWrite=0.
REQ-033 SHALL, when reset occurs mid-transfer, drop the current strobe at that edge; no further bus cycles of that transfer are issued.

Configuration
REQ-034 SHALL, with DMA_FILL_EN defined, latch src_addr as a 32-bit pattern when start occurs with fill_mode=1 (no bits forced to 0), skip READ, write the pattern to N consecutive words (WRITE to WRITE), and take N+1 cycles.
REQ-035 SHALL, without DMA_FILL_EN, ignore fill_mode and not synthesize the fill logic.

Verification
REQ-036 SHALL cover this copy case: memory words at 0x00,0x04,0x08 = A1,B2,C3; start with src=0x00, dst=0x40, N=3, grant=1 -> words at 0x40..0x48 = A1,B2,C3; done pulses 7 cycles after the start edge; irq=1.
REQ-037 SHALL cover this stall case: the same copy with grant=0 for 4 cycles during the second WRITE -> no strobes while grant=0; done arrives 4 cycles later; data is correct.
REQ-038 SHALL cover the zero-count case: N=0 -> DONE on the next cycle with no MemRead or MemWrite ever asserted; done=1; irq=1.
REQ-039 SHALL cover this abort case: abort in the third cycle of an N=4 copy -> IDLE next cycle; only 0x40 written; done=0; irq stays 0.
REQ-040 SHALL cover this fill case under DMA_FILL_EN: fill_mode=1, src=0xDEADBEEF, dst=0x20, N=2 -> 0x20 and 0x24 = 0xDEADBEEF; done 3 cycles after the start edge.
REQ-041 SHALL cover this reset case: reset=0 during a WRITE -> all outputs 0 and busy=0 at that edge; irq cleared.
